axi_master_bridge: RTL
======================

AXI_MASTER_BRIDGE -- requirements
Module: axi_master_bridge

Interface
REQ-001 Parameter RD_ID, default 4'h0: ID driven on arid.
REQ-002 Parameter WR_ID, default 4'h1: ID driven on awid.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cache_ren_i  input  1  cache-side read request, held until the burst completes.
REQ-006 cache_raddr_i  input  32  read start address.
REQ-007 cache_rlen_i  input  4  read beats minus one (0 = single, 7 = line).
REQ-008 rdata_o  output  32  read beat data.
REQ-009 rdata_valid_o  output  1  one pulse per accepted read beat.
REQ-010 cache_wen_i  input  1  cache-side write request, held until the burst completes.
REQ-011 cache_waddr_i  input  32  write start address.
REQ-012 cache_wdata_i  input  32  current write beat; upstream advances it after each wdata_resp_o.
REQ-013 cache_wlen_i  input  4  write beats minus one.
REQ-014 wdata_resp_o  output  1  one pulse per completed write beat.
REQ-015 AXI4 master ports: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1 out; arready 1 in.
REQ-016 AXI4 master ports: rdata 32, rlast 1, rvalid 1 in; rready 1 out.
REQ-017 AXI4 master ports: awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1 out; awready 1 in.
REQ-018 AXI4 master ports: wdata 32, wstrb 4, wlast 1, wvalid 1 out; wready 1 in.
REQ-019 AXI4 master ports: bvalid 1 in, bresp 2 in; bready 1 out.

Function
REQ-020 The read and write FSMs SHALL be independent and SHALL be able to run concurrently.
REQ-021 Read FSM states: R_IDLE, R_ADDR, R_DATA, R_GAP.
- R_IDLE with cache_ren_i=1: latch address and length; go to R_ADDR.
REQ-022 R_ADDR drives arvalid=1 from registers.
- araddr = latched address; arlen = {4'h0, latched length}; arsize = 3'b010; arburst = 2'b01.
- On arvalid&&arready: go to R_DATA.
REQ-023 In R_DATA, rready=1.
- rdata_o = rdata; rdata_valid_o = rvalid&&rready, combinational with zero latency.
- On a handshake with rlast=1: go to R_GAP.
REQ-024 R_GAP SHALL last exactly one cycle, then return to R_IDLE, so a still-asserted stale cache_ren_i cannot relaunch a burst.
REQ-025 Burst end SHALL be determined by rlast only; the beat count is not checked.
REQ-026 Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP, W_GAP.
- W_IDLE with cache_wen_i=1: latch address and length; clear the beat counter; go to W_ADDR.
REQ-027 W_ADDR drives awvalid=1 with awlen, awsize and awburst encoded as for reads.
- On awvalid&&awready: go to W_DATA.
REQ-028 In W_DATA: wvalid=1, wdata=cache_wdata_i, wstrb=4'hF, wlast=(beat counter == latched length).
REQ-029 On a W handshake with wlast=0: wdata_resp_o=1 in the same cycle, and the beat counter increments.
REQ-030 On a W handshake with wlast=1: no wdata_resp_o pulse; go to W_RESP.
REQ-031 In W_RESP, bready=1.
- On bvalid: wdata_resp_o=1 for that cycle, regardless of bresp; go to W_GAP.
- W_GAP lasts one cycle, then returns to W_IDLE.
REQ-032 Total wdata_resp_o pulses per burst SHALL equal length+1, and the final pulse SHALL be the B response.
REQ-033 Boundary: length 0 SHALL go W_DATA -> W_RESP on the first handshake, with zero intermediate pulses.
- Ready asserted in the same cycle valid first rises SHALL complete in that cycle.
- wready or rvalid held low SHALL stall the FSM with all outputs stable.
REQ-034 Requests arriving while the corresponding FSM is non-idle SHALL be ignored until it returns to idle.

Reset
REQ-035 On rst, both FSMs SHALL go to idle and the beat counter and latched registers SHALL clear.
- All outputs SHALL be 0: arvalid, rready, awvalid, wvalid, wlast, bready, rdata_valid_o, wdata_resp_o.
- The constant fields (arid, awid, arsize, arburst, awsize, awburst, wstrb) SHALL hold their fixed values.
REQ-036 rst asserted mid-burst SHALL abandon the burst immediately; no completion pulse SHALL be emitted.

Verification
REQ-037 Read line:
- Stimulus: ren, raddr=0x1FC0_0020, rlen=7; arready after 2 cycles; 8 rvalid beats with gaps.
- Response: araddr=0x1FC0_0020, arlen=8'h07; exactly 8 rdata_valid_o pulses in order; R_IDLE after 1 gap cycle.
REQ-038 Read single:
- Stimulus: rlen=0; arready tied 1.
- Response: arvalid high for 1 cycle; one pulse; rdata_o = the beat's data.
REQ-039 Write line:
- Stimulus: wlen=7; wready toggles 1/0; bvalid 3 cycles after the last beat.
- Response: 7 pulses on W handshakes; wlast only on beat 8; 8th pulse coincides with bvalid.
REQ-040 Write single:
- Stimulus: wlen=0, wdata=0xDEAD_BEEF, bresp=2'b10.
- Response: wlast=1 on the first beat; exactly one pulse, on B.
REQ-041 Concurrent:
- Stimulus: read line and write line issued in the same cycle.
- Response: both complete with correct pulse counts and no interference.
REQ-042 Reset:
- Stimulus: rst during read beat 4 and write beat 3.
- Response: all valids and pulses 0 next cycle; a fresh burst afterwards behaves per REQ-037.

Source files
------------

// File: rtl/axi_master_bridge_if.sv
// AXI4 master-side bus bundle (AR/R/AW/W/B) used by axi_master_bridge.
// The master modport is the bridge's view; slave is the memory side.
interface axi_master_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/axi_master_bridge.sv
// Cache-to-AXI4 master bridge: each held cache request becomes one INCR burst,
// with independent read and write sequencers that may run concurrently.
//
// state  | meaning
// R_IDLE | waiting for cache_ren_i; latches address/length
// R_ADDR | arvalid asserted from latched registers
// R_DATA | rready asserted; rlast handshake ends the burst
// R_GAP  | one dead cycle so a stale request cannot relaunch
// W_IDLE | waiting for cache_wen_i; latches address/length, clears beat count
// W_ADDR | awvalid asserted from latched registers
// W_DATA | wvalid asserted; beat count drives wlast
// W_RESP | bready asserted; B handshake gives the final pulse
// W_GAP  | one dead cycle before accepting a new write
module axi_master_bridge #(
    parameter logic [3:0] RD_ID = 4'h0,
    parameter logic [3:0] WR_ID = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_ren_i,
    input  logic [31:0] cache_raddr_i,
    input  logic [3:0]  cache_rlen_i,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    input  logic        cache_wen_i,
    input  logic [31:0] cache_waddr_i,
    input  logic [31:0] cache_wdata_i,
    input  logic [3:0]  cache_wlen_i,
    output logic        wdata_resp_o,
    axi_master_bridge_if.master axi
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_GAP} r_state_t;
    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_GAP} w_state_t;

    r_state_t    r_state, r_state_nxt;
    logic        r_latch;
    logic [31:0] r_addr_q;
    logic [3:0]  r_len_q;

    w_state_t    w_state, w_state_nxt;
    logic        w_latch;
    logic [31:0] w_addr_q;
    logic [3:0]  w_len_q;
    logic [3:0]  w_cnt_q;
    logic        w_last;
    logic        w_hs;

    // ---------------- read sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            r_addr_q <= '0;
            r_len_q  <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (r_latch) begin
                r_addr_q <= cache_raddr_i;
                r_len_q  <= cache_rlen_i;
            end
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        r_latch     = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (cache_ren_i) begin
                    r_latch     = 1'b1;
                    r_state_nxt = R_ADDR;
                end
            end
            R_ADDR: if (axi.arready) r_state_nxt = R_DATA;
            // Burst end is taken from rlast alone; beats are not counted.
            R_DATA: if (axi.rvalid && axi.rlast) r_state_nxt = R_GAP;
            R_GAP:  r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign axi.arid    = RD_ID;
    assign axi.araddr  = r_addr_q;
    assign axi.arlen   = {4'h0, r_len_q};
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = (r_state == R_ADDR);
    assign axi.rready  = (r_state == R_DATA);

    assign rdata_o       = axi.rdata;
    assign rdata_valid_o = !rst && (r_state == R_DATA) && axi.rvalid;

    // ---------------- write sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            w_addr_q <= '0;
            w_len_q  <= '0;
            w_cnt_q  <= '0;
        end else begin
            w_state <= w_state_nxt;
            if (w_latch) begin
                w_addr_q <= cache_waddr_i;
                w_len_q  <= cache_wlen_i;
                w_cnt_q  <= '0;
            end else if (w_hs && !w_last) begin
                w_cnt_q <= w_cnt_q + 4'd1;
            end
        end
    end

    assign w_last = (w_state == W_DATA) && (w_cnt_q == w_len_q);
    assign w_hs   = (w_state == W_DATA) && axi.wready;

    always_comb begin
        w_state_nxt = w_state;
        w_latch     = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (cache_wen_i) begin
                    w_latch     = 1'b1;
                    w_state_nxt = W_ADDR;
                end
            end
            W_ADDR: if (axi.awready) w_state_nxt = W_DATA;
            W_DATA: if (w_hs && w_last) w_state_nxt = W_RESP;
            W_RESP: if (axi.bvalid) w_state_nxt = W_GAP;
            W_GAP:  w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign axi.awid    = WR_ID;
    assign axi.awaddr  = w_addr_q;
    assign axi.awlen   = {4'h0, w_len_q};
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = (w_state == W_ADDR);
    assign axi.wvalid  = (w_state == W_DATA);
    assign axi.wdata   = cache_wdata_i;
    assign axi.wstrb   = 4'hF;
    assign axi.wlast   = w_last;
    assign axi.bready  = (w_state == W_RESP);

    // The last data beat is acknowledged by the B response, not by the W handshake;
    // bresp is deliberately not inspected.
    assign wdata_resp_o = !rst && ((w_hs && !w_last) ||
                                   ((w_state == W_RESP) && axi.bvalid));

endmodule
